// File: rtl/keymap_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keymap_decoder
// Description : Decodes PS/2 set-2 scancodes (E0/F0 prefixes) into per-key
//               press pulses, held levels and a sticky last-pressed latch.
//               Optional macro KEYMAP_TYPEMATIC_EN: a repeated make of a held
//               key re-pulses (auto-repeat).
// Revision    : 1.0 - initial release
// ============================================================================
module keymap_decoder #(
  parameter int                    NUM_KEYS = 8,
  parameter logic [9*NUM_KEYS-1:0] KEYMAP   = {9'h16B, 9'h174, 9'h172, 9'h175,
                                               9'h023, 9'h021, 9'h032, 9'h01C}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [7:0]          keycodeout,
  input  logic                latch_clr,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_latched,
  output logic                any_pulse
);

  localparam logic [7:0] c_byte_ext   = 8'hE0;
  localparam logic [7:0] c_byte_brk   = 8'hF0;
  localparam logic [7:0] c_byte_pause = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t r_state;

  logic                w_is_ext;
  logic                w_is_brk;
  logic                w_prefix;
  logic                w_pause;
  logic                w_make;
  logic                w_break;
  logic                w_hit;
  logic                w_fire;
  logic [NUM_KEYS-1:0] w_match_oh;

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    w_match_oh = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (KEYMAP[9*k +: 9] == {w_is_ext, keycodeout}) begin
        w_match_oh    = '0;
        w_match_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_is_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_is_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    w_prefix = !w_is_brk && ((keycodeout == c_byte_ext) || (keycodeout == c_byte_brk));
    w_pause  = (r_state == ST_IDLE) && (keycodeout == c_byte_pause);
    w_make   = rx_done_tick && !w_is_brk && !w_prefix && !w_pause;
    w_break  = rx_done_tick && w_is_brk;
    w_hit    = |w_match_oh;
  end

`ifdef KEYMAP_TYPEMATIC_EN
  assign w_fire = w_make && w_hit;
`else
  logic w_already;
  assign w_already = |(w_match_oh & key_held);
  assign w_fire    = w_make && w_hit && !w_already;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      key_pulse   <= '0;
      key_held    <= '0;
      key_latched <= '0;
      any_pulse   <= 1'b0;
    end else begin
      key_pulse <= w_fire ? w_match_oh : '0;
      any_pulse <= w_fire;

      if (w_fire)
        key_held <= key_held | w_match_oh;
      else if (w_break)
        key_held <= key_held & ~w_match_oh;

      // A make on the same edge as latch_clr takes priority.
      if (w_fire)
        key_latched <= w_match_oh;
      else if (latch_clr)
        key_latched <= '0;

      if (rx_done_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (keycodeout == c_byte_ext)
              r_state <= ST_EXT;
            else if (keycodeout == c_byte_brk)
              r_state <= ST_BRK;
            else
              r_state <= ST_IDLE;
          end
          ST_EXT: begin
            if (keycodeout == c_byte_ext)
              r_state <= ST_EXT;
            else if (keycodeout == c_byte_brk)
              r_state <= ST_EXT_BRK;
            else
              r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keymap_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keymap_decoder
// Description : Directed and random scancode streams checked against a
//               prefix-flag reference model of the default keymap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keymap_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] keycodeout = 8'h00;
  logic       latch_clr = 1'b0;
  logic [7:0] key_pulse;
  logic [7:0] key_held;
  logic [7:0] key_latched;
  logic       any_pulse;

  keymap_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .keycodeout   (keycodeout),
    .latch_clr    (latch_clr),
    .key_pulse    (key_pulse),
    .key_held     (key_held),
    .key_latched  (key_latched),
    .any_pulse    (any_pulse)
  );

  always #5 clk = ~clk;

  // Key table: A, B, C, D, up, down, right, left; bit 8 marks E0-prefixed keys.
  logic [8:0] keymap_tbl [8] = '{9'h01C, 9'h032, 9'h021, 9'h023,
                                 9'h175, 9'h172, 9'h174, 9'h16B};
  logic [7:0] pool [14] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h75, 8'h72, 8'h74,
                            8'h6B, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'h5A};

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] e_pulse, e_held, e_latched;
  bit         m_ext, m_brk;

`ifdef KEYMAP_TYPEMATIC_EN
  localparam bit c_repeat = 1'b1;
`else
  localparam bit c_repeat = 1'b0;
`endif

  function automatic int lookup(input bit ext, input logic [7:0] b);
    for (int k = 0; k < 8; k++)
      if (keymap_tbl[k] == {ext, b}) return k;
    return -1;
  endfunction

  task automatic model_reset();
    e_pulse = '0; e_held = '0; e_latched = '0; m_ext = 0; m_brk = 0;
  endtask

  // Reference behaviour for one received byte plus the latch_clr level.
  task automatic model_byte(input logic [7:0] b, input bit clr);
    int  k;
    bit  fired = 0;
    e_pulse = '0;
    if (m_brk) begin
      k = lookup(m_ext, b);
      if (k >= 0) e_held[k] = 1'b0;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1 && !m_ext) begin
      m_ext = 0;
    end else begin
      k = lookup(m_ext, b);
      if (k >= 0 && (c_repeat || !e_held[k])) begin
        e_pulse   = 8'(1 << k);
        e_latched = 8'(1 << k);
        e_held[k] = 1'b1;
        fired = 1;
      end
      m_ext = 0;
    end
    if (clr && !fired) e_latched = '0;
  endtask

  task automatic check(input string tag);
    n_assert++;
    assert (key_pulse === e_pulse) else begin
      n_fail++; $error("FAIL %s key_pulse: observed %h expected %h", tag, key_pulse, e_pulse);
    end
    n_assert++;
    assert (key_held === e_held) else begin
      n_fail++; $error("FAIL %s key_held: observed %h expected %h", tag, key_held, e_held);
    end
    n_assert++;
    assert (key_latched === e_latched) else begin
      n_fail++; $error("FAIL %s key_latched: observed %h expected %h", tag, key_latched, e_latched);
    end
    n_assert++;
    assert (any_pulse === (e_pulse != 0)) else begin
      n_fail++; $error("FAIL %s any_pulse: observed %b expected %b", tag, any_pulse, e_pulse != 0);
    end
  endtask

  // Called at a negedge: strobe one byte, check the result, then one quiet cycle.
  task automatic send(input logic [7:0] b, input bit clr, input string tag);
    rx_done_tick = 1'b1; keycodeout = b; latch_clr = clr;
    model_byte(b, clr);
    @(negedge clk);
    rx_done_tick = 1'b0; latch_clr = 1'b0;
    check(tag);
    @(negedge clk);
    e_pulse = '0;
    check({tag, "_idle"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset");
    reset = 1'b1;
    @(negedge clk);
    check("post_reset");

    send(8'h1C, 0, "make_A");
    send(8'hE0, 0, "e0");
    send(8'h75, 0, "make_up");
    send(8'h75, 0, "bare_75");
    send(8'hE0, 0, "e0");
    send(8'hF0, 0, "f0");
    send(8'h75, 0, "brk_up");
    send(8'h1C, 0, "remake_A");
    send(8'hF0, 0, "f0");
    send(8'h1C, 0, "brk_A");
    send(8'h1C, 0, "make_A2");
    send(8'h32, 0, "make_B");
    send(8'h21, 1, "clr_vs_C");
    rx_done_tick = 1'b0; latch_clr = 1'b1; e_latched = '0;
    @(negedge clk);
    latch_clr = 1'b0;
    check("latch_clr");
    send(8'h5A, 0, "unmapped");
    send(8'hE1, 0, "e1");
    send(8'hF0, 0, "f0");
    send(8'h2B, 0, "brk_unmapped");
    send(8'h23, 0, "make_D_idle");
    send(8'hE0, 0, "e0");
    send(8'hE0, 0, "e0_e0");
    send(8'h72, 0, "make_down");

    // Reset in the middle of an E0 prefix, with a strobe pending.
    send(8'hE0, 0, "e0_pre_rst");
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset");
    rx_done_tick = 1'b1; keycodeout = 8'h1C;
    @(negedge clk);
    rx_done_tick = 1'b0;
    check("reset_hold");
    reset = 1'b1;
    send(8'h75, 0, "bare_after_rst");

    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      send(b, ($urandom_range(0, 7) == 0), "rand");
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
